// File: rtl/string_char_streamer.sv
// Fetches one packed string from the display string ROM and streams its
// characters leftmost-first to the glyph renderer, optionally trimming trailing blanks.
module string_char_streamer #(
  parameter int CHAR_WIDTH = 5,
  parameter int STRING_NUM = 7,
  parameter int MAX_CHAR   = 11,
  parameter int SPACE_CODE = 28,
  localparam int AW        = $clog2(STRING_NUM + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [AW-1:0]                  req_addr,
  input  logic                           req_trim,
  output logic [AW-1:0]                  rom_addr,
  input  logic [CHAR_WIDTH*MAX_CHAR-1:0] rom_data,
  output logic                           char_valid,
  input  logic                           char_ready,
  output logic [CHAR_WIDTH-1:0]          char_code,
  output logic [3:0]                     char_idx,
  output logic                           char_last,
  output logic                           done,
  output logic                           err
);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid-side payload holds stable until that edge.

  localparam int SW = CHAR_WIDTH * MAX_CHAR;
  localparam logic [AW-1:0]         NUM_STR = AW'(STRING_NUM);
  localparam logic [3:0]            MAX_LEN = 4'(MAX_CHAR);
  localparam logic [CHAR_WIDTH-1:0] SPACE   = CHAR_WIDTH'(SPACE_CODE);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t        state, state_next;
  logic [SW-1:0] holding;
  logic [3:0]    idx, len, trim_len, load_len;
  logic          trim;
  logic          addr_ok;

  assign addr_ok  = (req_addr < NUM_STR);
  assign load_len = trim ? trim_len : MAX_LEN;

  // Length up to and including the last non-blank character; interior blanks count.
  always_comb begin
    trim_len = '0;
    for (int i = 0; i < MAX_CHAR; i++) begin
      if (rom_data[(MAX_CHAR-1-i)*CHAR_WIDTH +: CHAR_WIDTH] != SPACE) trim_len = 4'(i + 1);
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    char_valid = 1'b0;
    char_code  = '0;
    char_idx   = '0;
    char_last  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && addr_ok) state_next = LOAD;
      end
      LOAD: state_next = (load_len == 4'd0) ? IDLE : STREAM;
      STREAM: begin
        char_valid = 1'b1;
        char_code  = holding[SW-1 -: CHAR_WIDTH];
        char_idx   = idx;
        char_last  = (idx == len - 4'd1);
        if (char_ready && char_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The holding register shifts left on each handshake so the current
  // character always sits in the MSBs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      trim     <= 1'b0;
      holding  <= '0;
      idx      <= '0;
      len      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (addr_ok) begin
              rom_addr <= req_addr;
              trim     <= req_trim;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          holding <= rom_data;
          len     <= load_len;
          idx     <= '0;
          if (load_len == 4'd0) done <= 1'b1;
        end
        STREAM: begin
          if (char_ready) begin
            if (char_last) begin
              done <= 1'b1;
            end else begin
              idx     <= idx + 4'd1;
              holding <= holding << CHAR_WIDTH;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/string_char_streamer.md
# string_char_streamer

Sequencer that sits directly downstream of the display string ROM. It accepts a string-select request, drives the ROM address, and captures the packed 11-character string. It then streams the characters one per handshake, leftmost first, to the glyph/pixel renderer. Optional trailing-space trimming lets the renderer stop early on short labels.

## Interface
- CHAR_WIDTH, 5, bits per character code
- STRING_NUM, 7, number of valid strings in the ROM
- MAX_CHAR, 11, characters per string
- SPACE_CODE, 28, code treated as blank for trimming
- AW (localparam), $clog2(STRING_NUM+1), request/ROM address width
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  string request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_addr  in  AW  string index to display
- req_trim  in  1  sampled with request; 1 = drop trailing SPACE_CODE characters
- rom_addr  out  AW  registered address to string ROM (combinational ROM)
- rom_data  in  CHAR_WIDTH*MAX_CHAR  packed string; char 0 (leftmost) in MSBs
- char_valid  out  1  char_code/char_idx/char_last valid
- char_ready  in  1  renderer accepts current character
- char_code  out  CHAR_WIDTH  current character code
- char_idx  out  4  position of current character, 0..MAX_CHAR-1
- char_last  out  1  current character is the final one emitted
- done  out  1  one-cycle pulse after the final character handshake
- err  out  1  one-cycle pulse when req_addr >= STRING_NUM is rejected

## Operation
- FSM states: IDLE, LOAD, STREAM.
- IDLE:
  - req_ready=1.
  - On req_valid with req_addr < STRING_NUM: latch rom_addr<=req_addr and trim<=req_trim, go to LOAD.
  - On req_valid with req_addr >= STRING_NUM: pulse err next cycle, rom_addr unchanged, stay in IDLE.
- LOAD (exactly 1 cycle):
  - Capture rom_data into the holding register.
  - Compute len. If trim=0, len=MAX_CHAR. If trim=1, len = index of last non-SPACE_CODE char + 1. Interior spaces are always kept.
  - If len=0, go to IDLE with a done pulse and no characters emitted. Otherwise set idx=0 and go to STREAM.
- STREAM:
  - char_valid=1, char_code = holding[(MAX_CHAR-1-idx)*CHAR_WIDTH +: CHAR_WIDTH], char_idx=idx, char_last=(idx==len-1).
  - On char_valid&&char_ready: if char_last, go to IDLE and pulse done; otherwise idx<=idx+1.
  - Without a handshake, all char_* outputs hold stable.
- The holding register is used exclusively during streaming, so rom_data changes after LOAD have no effect.
- New requests are ignored while not in IDLE (req_ready=0).

## Timing
- Reset values: req_ready=0 during reset cycle then 1 (IDLE), rom_addr=0, char_valid=0, char_code=0, char_idx=0, char_last=0, done=0, err=0.
- Request accepted at edge N → LOAD in cycle N+1 → first char_valid in cycle N+2.
- Throughput is 1 character/cycle while char_ready is held high. An untrimmed string occupies 11 consecutive valid cycles.
- done is high the cycle after the last handshake. IDLE is entered that same cycle, so req_ready=1 and back-to-back requests are possible.
- err is high the cycle after the bad request. No LOAD, no char_valid.
- rst_n low in any state, including mid-stream: next edge forces IDLE and reset values. A partial string is abandoned with no done pulse.
- char_ready high while char_valid is low has no effect.

## Test plan
- addr 0, trim=0, char_ready=1 → codes 6,0,12,4,28,19,8,12,4,26,28 on idx 0..10 in consecutive cycles. char_last only on idx 10, done 1 cycle later, first valid 2 cycles after acceptance.
- addr 0, trim=1 → 10 characters ending with code 26 at idx 9 with char_last=1. Interior space (idx 4, code 28) is still emitted.
- addr 6, trim=0, char_ready low for 3 cycles at idx 5 → code 18/idx 5 held stable for all 3 cycles. Stream resumes with 19,0,19,20,18.
- req_addr=7 → err pulse for exactly 1 cycle; char_valid never rises; rom_addr keeps its previous value; a following request for addr 1 streams 23,28,15,14,18,8,19,8,14,13,26.
- ROM stub returns all 28s, trim=1 → no char_valid; done pulses 2 cycles after acceptance.
- rst_n asserted low at idx 3 of addr 5 → next cycle char_valid=0, req_ready=1, done=0. A new request for addr 5 restarts at idx 0 with code 5.
